// File: rtl/instr_enc_if.sv
// instr_enc_if: symbolic-instruction input channel and encoded-word output channel
// of instr_encoder.
//   in_valid/in_ready      input handshake
//   in_op, in_rs, in_rt,   mnemonic code and register fields
//   in_rd
//   in_imm                 immediate (I-type) or jump target (J)
//   in_last                marks the final instruction of a program
//   out_valid/out_ready    output handshake
//   out_instr, out_addr    encoded word and its word address
// Modport master drives the instruction stream and accepts words.
// Modport slave is the encoder.
interface instr_enc_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [25:0]       in_imm;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: sequential MIPS instruction encoder. It accepts one symbolic
// instruction per input handshake and emits the registered 32-bit machine word
// with its word address. A load FSM (IDLE/LOAD/DONE) runs a program from start to
// the last instruction, or until the last address is used.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   start  one-cycle pulse beginning a load (ignored during LOAD)
//   done   high in DONE
//   err    sticky error: illegal op, bad immediate, address overflow
//   bus    instr_enc_if slave modport (input and output channels)
// Optional feature: define INSTR_ENC_RANGE_CHK_EN to enable the I-type immediate
// range check. A violating instruction is encoded as a NOP and sets err.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic        err,
  instr_enc_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  localparam logic [ADDR_W-1:0] AddrMax = '1;

  state_e            state_q;
  logic              out_valid_q;
  logic [31:0]       out_instr_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [ADDR_W-1:0] cnt_q;    // address of the next word when no word is held
  logic              last_q;   // held word carried in_last
  logic              err_q;

  logic              out_hs;
  logic              in_hs;
  logic              in_ready;
  logic              term;
  logic [ADDR_W-1:0] cap_addr;
  logic [31:0]       enc_instr;
  logic              enc_bad;

  assign out_hs = out_valid_q & bus.out_ready;
  // The held word ends the load. Nothing more is accepted behind it, so the
  // address never wraps and no word follows the last one.
  assign term     = out_valid_q & (last_q | (out_addr_q == AddrMax));
  assign in_ready = (state_q == StLoad) & (~out_valid_q | (bus.out_ready & ~term));
  assign in_hs    = bus.in_valid & in_ready;
  // A capture with a word held implies that word is leaving in the same cycle.
  assign cap_addr = out_valid_q ? out_addr_q + ADDR_W'(1) : cnt_q;

  always_comb begin
    enc_instr = '0;
    enc_bad   = 1'b0;
    case (bus.in_op)
      4'd0:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h20};
      4'd1:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h21};
      4'd2:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h24};
      4'd3:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h25};
      4'd4:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h27};
      4'd5:  enc_instr = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'd0, 6'h22};
      4'd6:  enc_instr = {6'h08, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd7:  enc_instr = {6'h0C, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd8:  enc_instr = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd9:  enc_instr = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd10: enc_instr = {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm[15:0]};
      4'd11: enc_instr = {6'h02, bus.in_imm};
      default: enc_bad = 1'b1;
    endcase
`ifdef INSTR_ENC_RANGE_CHK_EN
    // ANDI zero-extends its immediate; the other I-types sign-extend.
    if (bus.in_op == 4'd7) begin
      if (bus.in_imm[25:16] != 10'd0) enc_bad = 1'b1;
    end else if (bus.in_op == 4'd6 || bus.in_op == 4'd8 ||
                 bus.in_op == 4'd9 || bus.in_op == 4'd10) begin
      if (bus.in_imm[25:16] != {10{bus.in_imm[15]}}) enc_bad = 1'b1;
    end
`endif
    if (enc_bad) enc_instr = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q <= StLoad;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        StLoad: begin
          if (out_hs) begin
            if (term) begin
              state_q <= StDone;
              if (!last_q) err_q <= 1'b1;
            end else begin
              cnt_q <= out_addr_q + ADDR_W'(1);
            end
          end
          if (in_hs) begin
            out_valid_q <= 1'b1;
            out_instr_q <= enc_instr;
            out_addr_q  <= cap_addr;
            last_q      <= bus.in_last;
            if (enc_bad) err_q <= 1'b1;
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign done          = (state_q == StDone);
  assign err           = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential MIPS instruction encoder: the write-side counterpart of the instruction decode path. It accepts one symbolic instruction per handshake (mnemonic code plus register/immediate fields) and emits the 32-bit machine word with a word address, ready to be written into instruction memory. A small load FSM sequences a program from `start` to the last instruction. It also flags illegal mnemonics, out-of-range immediates and address overflow.

## Interface
- `ADDR_W`, default 8: width of the word-address counter; program capacity is 2^ADDR_W words.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a program load.
- `in_valid`  in  1  input fields valid.
- `in_ready`  out  1  encoder can accept input.
- `in_op`  in  4  mnemonic code. 0 ADD, 1 ADDU, 2 AND, 3 OR, 4 NOR, 5 SUB, 6 ADDI, 7 ANDI, 8 BEQ, 9 LW, 10 SW, 11 J; 12–15 are illegal.
- `in_rs`, `in_rt`, `in_rd`  in  5 each  register numbers.
- `in_imm`  in  26  immediate (I-type uses it as a two's-complement value) or jump target (J).
- `in_last`  in  1  marks the final instruction of the program.
- `out_valid`  out  1  encoded word valid.
- `out_ready`  in  1  memory side accepts the word.
- `out_instr`  out  32  encoded word.
- `out_addr`  out  ADDR_W  word address for `out_instr`.
- `done`  out  1  high in DONE.
- `err`  out  1  sticky error; cleared by `rst` or `start`.

## Operation
- FSM states: IDLE, LOAD, DONE.
  - IDLE → LOAD on `start`. The same edge clears the address counter and `err`.
  - LOAD → DONE on the output handshake of the word captured with `in_last=1`.
  - LOAD → DONE on the output handshake at address 2^ADDR_W−1. This sets `err` unless that word carried `in_last`.
  - DONE → LOAD on `start`, with the same clears as from IDLE.
  - `start` is ignored while in LOAD.
- `in_ready` is 1 only in LOAD, and only when (`out_valid`=0 or `out_ready`=1). Input handshake = `in_valid & in_ready`.
- The address counter increments by 1 on each output handshake. It must never wrap inside one load.
- R-type encoding (ops 0–5):
  - Fields: opcode 0, `rs`[25:21], `rt`[20:16], `rd`[15:11], shamt 0.
  - funct: ADD 0x20, ADDU 0x21, AND 0x24, OR 0x25, NOR 0x27, SUB 0x22.
- I-type encoding:
  - Opcodes: ADDI 0x08, ANDI 0x0C, BEQ 0x04, LW 0x23, SW 0x2B.
  - Fields: `rs`[25:21], `rt`[20:16], `in_imm[15:0]`[15:0]. `in_rd` is ignored.
- J encoding: opcode 0x02, `in_imm[25:0]` in [25:0]. The register fields are ignored.
- Illegal op (12–15): emit 0x00000000 (NOP) at the next address and set `err`. The load continues.

## Timing
- Latency: `out_valid` rises the cycle after the input handshake; the word is registered.
- Throughput: one word per cycle while `out_ready`=1.
- While `out_valid`=1 and `out_ready`=0, `out_instr` and `out_addr` must hold stable and `in_ready`=0.
- Simultaneous input and output handshake in the same cycle: the new word replaces the old one and the address advances by exactly 1.
- Reset values: state IDLE, `out_valid`=0, `out_instr`=0, `out_addr`=0, `in_ready`=0, `done`=0, `err`=0.
- `rst` mid-load discards any pending word without a handshake.
- `start` and `rst` asserted in the same cycle: `rst` wins.

## Configuration
- `INSTR_ENC_RANGE_CHK_EN` defined: I-type immediate range check is compiled in.
  - ADDI, BEQ, LW, SW require `in_imm[25:16]` to equal a replication of `in_imm[15]`.
  - ANDI requires `in_imm[25:16]`=0.
  - A violation emits a NOP and sets `err`.
- Macro undefined: no check. `in_imm[25:16]` is silently dropped and `err` is set only by illegal ops or overflow.

## Test plan
- ADD test: `start`, then ADD rs=1 rt=2 rd=3 with `in_last`=1.
  - Required: `out_instr`=0x00221820, `out_addr`=0.
  - `done`=1 the cycle after the output handshake; `err`=0.
- Stream test: stream ADDI rt=8 rs=0 imm=0x3FFFFFF, LW rt=9 rs=29 imm=4, J imm=0x100 (last).
  - Required words: 0x2008FFFF @0, 0x8FA90004 @1, 0x08000100 @2, back-to-back with `out_ready`=1.
- Backpressure test: hold `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: word and address stable, `in_ready`=0, no word lost or duplicated.
- Illegal-op test: op=13, then SUB rs=4 rt=5 rd=6 (last).
  - Required: 0x00000000 @0 with `err`=1, then 0x00853022 @1; `err` stays 1 until the next `start`.
- Range-check test: ANDI rs=1 rt=1 imm=0x10000.
  - With the macro: 0x00000000 and `err`=1.
  - Without the macro: 0x30210000 and `err`=0.
- Overflow and reset tests, `ADDR_W`=2:
  - Four words with no `in_last`: DONE after address 3, `err`=1.
  - `rst` asserted mid-stream returns all outputs to their reset values.
